// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snake_pkg
//  Description : Shared direction encoding, helpers and grid constants.
//  Revision    : 1.0
// ============================================================================
package snake_pkg;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_UP    = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    localparam int GRID_SIZE_X = 16;
    localparam int GRID_SIZE_Y = 16;

    // Flipping the MSB maps right<->left and up<->down.
    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage : snake_pkg
`default_nettype wire

// File: rtl/dir_cmd_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : dir_cmd_queue_if
//  Description : Key/step inputs and queued-direction outputs of the queue.
//  Revision    : 1.0
// ============================================================================
interface dir_cmd_queue_if #(
    parameter int DEPTH = 4
) ();
    logic                         start;
    logic [1:0]                   key_dir;
    logic                         key_valid;
    logic                         step;
    logic [1:0]                   dir_out;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         full;
    logic                         empty;
    logic                         dropped;

    modport master (
        output start, key_dir, key_valid, step,
        input  dir_out, count, full, empty, dropped
    );

    modport slave (
        input  start, key_dir, key_valid, step,
        output dir_out, count, full, empty, dropped
    );
endinterface : dir_cmd_queue_if
`default_nettype wire

// File: rtl/dir_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dir_fifo
//  Description : DEPTH x 2-bit circular FIFO exposing head and tail entries.
//  Revision    : 1.0
// ============================================================================
module dir_fifo #(
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       flush_i,
    input  wire logic                       push_i,
    input  wire logic                       pop_i,
    input  wire logic [1:0]                 wdata_i,
    output logic      [1:0]                 rdata_o,
    output logic      [1:0]                 tail_o,
    output logic      [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             w_push;
    logic             w_pop;

    // Occupancy guards keep the FIFO safe even if a caller misbehaves.
    assign w_push = push_i & (count_q != CNT_W'(DEPTH));
    assign w_pop  = pop_i  & (count_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'd0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign tail_o  = mem_q[wr_ptr_q - 1'b1];
    assign count_o = count_q;

endmodule : dir_fifo
`default_nettype wire

// File: rtl/dir_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : dir_cmd_queue
//  Description : Filters direction key presses and releases one per game step.
//  Revision    : 1.0
// ============================================================================
module dir_cmd_queue
    import snake_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter logic [1:0] INIT_DIR = DIR_RIGHT
) (
    input  wire logic       clk,
    input  wire logic       rst,
    dir_cmd_queue_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [1:0]       dir_out_q;
    logic [1:0]       dir_out_d;
    logic             dropped_q;
    logic             dropped_d;
    logic [1:0]       w_head;
    logic [1:0]       w_tail;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic [1:0]       w_ref_dir;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (w_count == CNT_W'(DEPTH));
    assign w_empty = (w_count == '0);

    // Compare against the newest accepted command, not the one on screen.
    assign w_ref_dir = w_empty ? dir_out_q : w_tail;
    assign w_accept  = (bus.key_dir != w_ref_dir) &&
                       (bus.key_dir != opposite_dir(w_ref_dir));
    assign w_push    = bus.key_valid & ~bus.start & ~w_full & w_accept;
    assign w_pop     = bus.step & ~bus.start & ~w_empty;

    dir_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.start),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i (bus.key_dir),
        .rdata_o (w_head),
        .tail_o  (w_tail),
        .count_o (w_count)
    );

    always_comb begin
        dir_out_d = dir_out_q;
        dropped_d = 1'b0;
        if (bus.start) begin
            dir_out_d = INIT_DIR;
        end else begin
            if (w_pop) begin
                dir_out_d = w_head;
            end
            dropped_d = bus.key_valid & ~w_push;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_out_q <= INIT_DIR;
            dropped_q <= 1'b0;
        end else begin
            dir_out_q <= dir_out_d;
            dropped_q <= dropped_d;
        end
    end

    assign bus.dir_out = dir_out_q;
    assign bus.dropped = dropped_q;
    assign bus.count   = w_count;
    assign bus.full    = w_full;
    assign bus.empty   = w_empty;

endmodule : dir_cmd_queue
`default_nettype wire

// File: tb/tb_dir_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dir_cmd_queue
//  Description : Directed self-checking bench for dir_cmd_queue.
//  Revision    : 1.0
// ============================================================================
module tb_dir_cmd_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    dir_cmd_queue_if #(.DEPTH(DEPTH)) ifc ();

    dir_cmd_queue #(
        .DEPTH    (DEPTH),
        .INIT_DIR (2'd0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // dir_out, count, dropped in one go
    task automatic chk3(input string tag, input logic [1:0] d, input logic [2:0] c, input logic dr);
        chk({tag, ".dir"},     8'(ifc.dir_out), 8'(d));
        chk({tag, ".count"},   8'(ifc.count),   8'(c));
        chk({tag, ".dropped"}, 8'(ifc.dropped), 8'(dr));
    endtask

    // One clock cycle with the given inputs, sampled 1 time unit after the edge.
    task automatic cyc(input logic kv, input logic [1:0] kd, input logic st, input logic sp);
        ifc.key_valid = kv;
        ifc.key_dir   = kd;
        ifc.start     = st;
        ifc.step      = sp;
        @(posedge clk);
        #1;
        ifc.key_valid = 1'b0;
        ifc.key_dir   = 2'd0;
        ifc.start     = 1'b0;
        ifc.step      = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        ifc.key_valid = 1'b0;
        ifc.key_dir   = 2'd0;
        ifc.start     = 1'b0;
        ifc.step      = 1'b0;
        rst = 1'b1;
        #12;
        chk3("reset", 2'd0, 3'd0, 1'b0);
        chk("reset.empty", 8'(ifc.empty), 8'd1);
        chk("reset.full",  8'(ifc.full),  8'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single press then step
        cyc(1'b1, 2'd1, 1'b0, 1'b0);
        chk3("t1.push", 2'd0, 3'd1, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        chk3("t1.step", 2'd1, 3'd0, 1'b0);

        // Two presses within one tick, two steps
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        chk3("t2.start", 2'd0, 3'd0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 1'b0);
        chk3("t2.push2", 2'd0, 3'd2, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        chk3("t2.step1", 2'd1, 3'd1, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        chk3("t2.step2", 2'd2, 3'd0, 1'b0);

        // Reverse and same-direction rejection against dir_out
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 1'b0);
        chk3("t3.rev", 2'd0, 3'd0, 1'b1);
        cyc(1'b1, 2'd0, 1'b0, 1'b0);
        chk3("t3.same", 2'd0, 3'd0, 1'b1);
        cyc(1'b0, 2'd0, 1'b0, 1'b0);
        chk3("t3.idle", 2'd0, 3'd0, 1'b0);
        cyc(1'b1, 2'd3, 1'b0, 1'b0);
        chk3("t3.down", 2'd0, 3'd1, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        chk3("t3.step", 2'd3, 3'd0, 1'b0);

        // Filter uses the queue tail, not dir_out
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 1'b0);
        cyc(1'b1, 2'd3, 1'b0, 1'b0);
        chk3("t4.revtail", 2'd0, 3'd1, 1'b1);
        cyc(1'b1, 2'd0, 1'b0, 1'b0);
        chk3("t4.right", 2'd0, 3'd2, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        chk3("t4.step1", 2'd1, 3'd1, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        chk3("t4.step2", 2'd0, 3'd0, 1'b0);

        // Fill with pointers offset by one so the pointers wrap
        cyc(1'b1, 2'd1, 1'b0, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        chk3("t5.pre", 2'd1, 3'd0, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 1'b0);
        chk3("t5.fill", 2'd1, 3'd4, 1'b0);
        chk("t5.full", 8'(ifc.full), 8'd1);
        cyc(1'b1, 2'd2, 1'b0, 1'b0);
        chk3("t5.over", 2'd1, 3'd4, 1'b1);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        chk3("t5.pop1", 2'd2, 3'd3, 1'b0);
        chk("t5.notfull", 8'(ifc.full), 8'd0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        chk3("t5.pop2", 2'd1, 3'd2, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        chk3("t5.pop3", 2'd2, 3'd1, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        chk3("t5.pop4", 2'd1, 3'd0, 1'b0);
        chk("t5.empty", 8'(ifc.empty), 8'd1);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        chk3("t5.popempty", 2'd1, 3'd0, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 1'b0);
        cyc(1'b1, 2'd3, 1'b0, 1'b0);
        chk3("t5.refill", 2'd1, 3'd2, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        chk3("t5.rpop1", 2'd2, 3'd1, 1'b0);
        // Push and pop in the same cycle
        cyc(1'b1, 2'd0, 1'b0, 1'b1);
        chk3("t5.pushpop", 2'd3, 3'd1, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        chk3("t5.rpop2", 2'd0, 3'd0, 1'b0);

        // Push and step on an empty queue: no bypass
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 1'b1);
        chk3("t6.nobypass", 2'd0, 3'd1, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        chk3("t6.step", 2'd1, 3'd0, 1'b0);

        // start flushes and discards a simultaneous press
        cyc(1'b1, 2'd2, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 1'b0);
        chk3("t7.fill3", 2'd1, 3'd3, 1'b0);
        cyc(1'b1, 2'd3, 1'b1, 1'b0);
        chk3("t7.start", 2'd0, 3'd0, 1'b0);
        chk("t7.empty", 8'(ifc.empty), 8'd1);

        // Async reset between clock edges
        cyc(1'b1, 2'd1, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 1'b1);
        chk3("t8.pre", 2'd1, 3'd1, 1'b0);
        ifc.step = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk3("t8.rst", 2'd0, 3'd0, 1'b0);
        chk("t8.empty", 8'(ifc.empty), 8'd1);
        ifc.step = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk3("t8.post", 2'd0, 3'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule : tb_dir_cmd_queue
`default_nettype wire

// File: doc/dir_cmd_queue.md
Name: dir_cmd_queue

Overview:
- Sits between key_control and snake_field: buffers decoded direction key presses and releases at most one per game step.
- Fast key sequences (e.g. up-then-left within one tick) are therefore not lost or collapsed.
- Rejects no-op presses (same direction) and 180-degree reversals against the most recently accepted direction.
- Its registered dir_out replaces the raw snake_dir feed into snake_field.

Parameters:
- DEPTH, 4, number of buffered direction commands; power of two, >= 2
- INIT_DIR, 2'd0, direction loaded into dir_out on reset and on start

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse, new game; flushes queue
- key_dir  input  2  decoded direction of current key press
- key_valid  input  1  one-cycle strobe qualifying key_dir
- step  input  1  one-cycle game tick pulse (tick & is_running)
- dir_out  output  2  direction applied for the current step
- count  output  $clog2(DEPTH+1)  number of queued commands
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- dropped  output  1  one-cycle pulse, key_valid press rejected

Behaviour:
- Reset (async, rst high), all registers cleared at once:
  - dir_out = INIT_DIR, count = 0, empty = 1, full = 0, dropped = 0
  - read/write pointers = 0
- Direction encoding: 0 right, 1 up, 2 left, 3 down. opposite(d) = d ^ 2'b10.
- Reference direction ref_dir = tail entry (last written) when count > 0, otherwise dir_out. It is evaluated from register state at the start of the cycle.
- Push condition: key_valid & ~full & (key_dir != ref_dir) & (key_dir != opposite(ref_dir)).
  - On push: key_dir is written at the write pointer, the write pointer increments modulo DEPTH, and count increments.
- Drop: key_valid without the push condition -> dropped = 1 on the next cycle (registered pulse); queue unchanged.
- Pop condition: step & ~empty.
  - On pop: dir_out <= head entry, the read pointer increments modulo DEPTH, and count decrements.
  - The new dir_out is visible the cycle after step.
- step with empty queue: dir_out holds; no pointer change.
- Push and pop in the same cycle: both are performed; count is unchanged.
  - If the queue is empty in that cycle, the pop is not performed (no bypass). The pushed entry is taken on the next step.
  - ref_dir for that push is the pre-pop tail, as defined above.
- Pointer wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. full/empty derive from count, never from pointer equality.
- start (synchronous) has priority over push and pop:
  - count <= 0, pointers <= 0, dir_out <= INIT_DIR, dropped <= 0
  - key_valid in the same cycle is discarded, with no dropped pulse.
- Reset asserted mid-operation: immediate return to reset values regardless of step/key_valid.
- Latency: key press to dir_out is at least one step; with an otherwise empty queue, the dir_out update is one cycle after the first step following the push.
- All outputs are registered except full and empty, which are combinational decodes of count.

Decomposition:
- Shared package snake_pkg:
  - direction localparams DIR_RIGHT/UP/LEFT/DOWN
  - function opposite_dir
  - GRID_SIZE constants shared with snake_field
- Sub-module dir_fifo: generic DEPTH x 2-bit circular FIFO.
  - Ports: push, pop, wdata, rdata (head), tail, count, flush.
  - The acceptance filter and dir_out register stay in dir_cmd_queue.

Test Plan:
- Reset, then key_dir=1 valid, step -> count 1 then 0; dir_out=1 the cycle after step; dropped never set.
- dir_out=0, push up(1) then left(2) within one tick; two steps -> dir_out 1 after the first step, 2 after the second.
- dir_out=0 empty queue, key_dir=2 (reverse) and key_dir=0 (same) -> both dropped pulses, count stays 0. Then key_dir=3 -> accepted.
- Queue tail=1, key_dir=3 -> dropped (reverse of tail, not of dir_out). key_dir=0 -> accepted.
- DEPTH=4: push 1,2,1,2, then 5th valid press 1 -> full=1, dropped pulse. Pop 4 times across steps verifies order and wrap-around; refill 2 more -> pointers wrap, order preserved.
- Queue count=3, start with simultaneous key_valid=1 -> next cycle count=0, dir_out=INIT_DIR, no dropped. Async rst pulsed mid-step -> outputs reset without a clock edge.
